// File: rtl/riscv_defs.sv
// Shared constants for the instruction fetch slice: NOP encoding, default
// reset PC and address width.
package riscv_defs;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a flush input; the head entry is
// visible on rdata whenever empty is low. DEPTH must be a power of two.
module sync_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
        if (flush) begin
            wr_ptr_d  = {AW{1'b0}};
            rd_ptr_d  = {AW{1'b0}};
            count_d   = {CW{1'b0}};
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + CW'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == {CW{1'b0}});
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: one-word-per-cycle ROM fetch into a FWFT buffer
// feeding decode. Optional perf counters enabled by macro IFU_PERF_CNT_EN.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = riscv_defs::RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    import riscv_defs::*;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned FW = 2 * XLEN;

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [31:0]   req_pc_q;
    logic [31:0]   req_pc_d;
    logic          inflight_q;
    logic          inflight_d;
    logic          kill_q;
    logic          kill_d;
    logic [OW-1:0] occ_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic [FW-1:0] head_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [CW-1:0] fifo_count_s;

    // Issue, push/pop and PC next-state; a redirect suppresses everything else.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        occ_s      = {1'b0, fifo_count_s} + OW'(inflight_q);
        issue_s    = (!rst_n) && (!jump_en) && (occ_s < OW'(DEPTH));
        push_s     = inflight_q && (!kill_q) && (!jump_en);
        pop_s      = (!fifo_empty_s) && id_ready && (!jump_en);
        inflight_d = issue_s;
        kill_d     = jump_en;
        if (jump_en) begin
            pc_d = jump_addr & 32'hFFFF_FFFC;
        end else if (issue_s) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch-side state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst_n),
        .flush (jump_en),
        .push  (push_s),
        .wdata ({req_pc_q, rom_rdata}),
        .pop   (pop_s),
        .rdata (head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    assign rom_req  = issue_s;
    assign rom_addr = pc_q;
    assign id_valid = !fifo_empty_s;
    // An empty buffer presents a NOP at the reset PC so decode never sees stale data.
    assign id_inst  = fifo_empty_s ? INST_NOP : head_s[XLEN-1:0];
    assign id_pc    = fifo_empty_s ? RESET_PC : head_s[FW-1:XLEN];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pop_s) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (jump_en) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed self-checking bench for ifu_prefetch; ROM returns its own address
// as data. A second instance starts near the top of the address space.
module tb_ifu_prefetch;

    logic        clk;
    logic        rst_n;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    logic        rom_req_w;
    logic [31:0] rom_addr_w;
    logic [31:0] rom_rdata_w;
    logic        jump_en_w;
    logic [31:0] jump_addr_w;
    logic        id_valid_w;
    logic        id_ready_w;
    logic [31:0] id_inst_w;
    logic [31:0] id_pc_w;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] fetch_cnt_w;
    logic [31:0] flush_cnt_w;
`endif

    int n_chk;
    int n_fail;

    ifu_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_inst   (id_inst),
        .id_pc     (id_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    ifu_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_req   (rom_req_w),
        .rom_addr  (rom_addr_w),
        .rom_rdata (rom_rdata_w),
        .jump_en   (jump_en_w),
        .jump_addr (jump_addr_w),
        .id_valid  (id_valid_w),
        .id_ready  (id_ready_w),
        .id_inst   (id_inst_w),
        .id_pc     (id_pc_w)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt_w),
        .flush_cnt (flush_cnt_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word content equals its byte address, one-cycle latency.
    always @(posedge clk) begin
        rom_rdata   <= rom_addr;
        rom_rdata_w <= rom_addr_w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b1;
        jump_en = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_rom_req", {31'd0, rom_req}, 32'd0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0000_0000);
        chk("rst_id_pc_w", id_pc_w, 32'hFFFF_FFF8);
        rst_n = 1'b0;
        #1;
        chk("rel_rom_req", {31'd0, rom_req}, 32'd1);
        chk("rel_rom_addr", rom_addr, 32'h0000_0000);
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = 32'h0;
        id_ready    = 1'b1;
        jump_en_w   = 1'b0;
        jump_addr_w = 32'h0;
        id_ready_w  = 1'b1;

        // Streaming fill from reset, including PC wrap on the second instance.
        do_reset();
        chk("s_rom_addr_w0", rom_addr_w, 32'hFFFF_FFF8);
        chk("s_rom_req_w0", {31'd0, rom_req_w}, 32'd1);
        cyc(); #1;
        chk("s_valid_c1", {31'd0, id_valid}, 32'd0);
        chk("s_rom_addr_c1", rom_addr, 32'h4);
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk("s_valid", {31'd0, id_valid}, 32'd1);
            chk("s_id_pc", id_pc, 32'(4 * k));
            chk("s_id_inst", id_inst, 32'(4 * k));
            chk("s_rom_addr", rom_addr, 32'(4 * (k + 2)));
            chk("w_id_pc", id_pc_w, 32'hFFFF_FFF8 + 32'(4 * k));
            chk("w_id_inst", id_inst_w, 32'hFFFF_FFF8 + 32'(4 * k));
        end

        // Backpressure: buffer fills to DEPTH then drains in order without gaps.
        id_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) cyc();
        #1;
        chk("bp_valid", {31'd0, id_valid}, 32'd1);
        chk("bp_head_pc", id_pc, 32'h0);
        chk("bp_rom_req", {31'd0, rom_req}, 32'd0);
        chk("bp_rom_addr", rom_addr, 32'h10);
        id_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            cyc(); #1;
            chk("bp_drain_valid", {31'd0, id_valid}, 32'd1);
            chk("bp_drain_pc", id_pc, 32'(4 * k));
        end

        // Redirect while a response is in flight.
        do_reset();
        cyc(); cyc(); cyc();
        jump_en = 1'b1; jump_addr = 32'h100;
        #1;
        chk("j_rom_req_blocked", {31'd0, rom_req}, 32'd0);
        cyc();
        jump_en = 1'b0;
        #1;
        chk("j_valid_p1", {31'd0, id_valid}, 32'd0);
        chk("j_rom_req_p1", {31'd0, rom_req}, 32'd1);
        chk("j_rom_addr_p1", rom_addr, 32'h100);
        cyc(); #1;
        chk("j_valid_p2", {31'd0, id_valid}, 32'd0);
        cyc(); #1;
        chk("j_valid_p3", {31'd0, id_valid}, 32'd1);
        chk("j_id_pc_p3", id_pc, 32'h100);
        chk("j_id_inst_p3", id_inst, 32'h100);
        cyc(); #1;
        chk("j_id_pc_p4", id_pc, 32'h104);

        // Misaligned target, then back-to-back redirects.
        jump_en = 1'b1; jump_addr = 32'h203;
        cyc(); #1;
        chk("ja_rom_addr", rom_addr, 32'h200);
        chk("ja_valid", {31'd0, id_valid}, 32'd0);
        jump_addr = 32'h300;
        cyc(); #1;
        chk("jb_valid", {31'd0, id_valid}, 32'd0);
        jump_addr = 32'h400;
        cyc();
        jump_en = 1'b0;
        #1;
        chk("jb_rom_req", {31'd0, rom_req}, 32'd1);
        chk("jb_rom_addr", rom_addr, 32'h400);
        chk("jb_valid_p1", {31'd0, id_valid}, 32'd0);
        cyc(); #1;
        chk("jb_valid_p2", {31'd0, id_valid}, 32'd0);
        cyc(); #1;
        chk("jb_valid_p3", {31'd0, id_valid}, 32'd1);
        chk("jb_id_pc_p3", id_pc, 32'h400);
`ifdef IFU_PERF_CNT_EN
        chk("perf_flush_cnt", flush_cnt, 32'd4);
        chk("perf_fetch_cnt", fetch_cnt, 32'd2);
`endif

        // Reset with three buffered entries.
        id_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        #1;
        chk("r3_valid", {31'd0, id_valid}, 32'd1);
        chk("r3_rom_addr", rom_addr, 32'h10);
        chk("r3_rom_req", {31'd0, rom_req}, 32'd0);
        rst_n = 1'b1;
        cyc(); #1;
        chk("r3_valid_after", {31'd0, id_valid}, 32'd0);
        chk("r3_rom_req_after", {31'd0, rom_req}, 32'd0);
        chk("r3_id_inst_after", id_inst, 32'h0000_0013);
`ifdef IFU_PERF_CNT_EN
        chk("r3_fetch_cnt", fetch_cnt, 32'd0);
        chk("r3_flush_cnt", flush_cnt, 32'd0);
`endif
        rst_n = 1'b0;
        #1;
        chk("r3_rel_rom_req", {31'd0, rom_req}, 32'd1);
        chk("r3_rel_rom_addr", rom_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
